// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// Requester IDs, access-size encodings and the request-field bundle.
package mem_arb_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } arb_req_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered requests.
// Push and pop are ignored when full or empty respectively.
module arb_id_fifo import mem_arb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     id_in_i,
  output logic                     head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] id_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = id_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) id_q[wr_ptr_q] <= id_in_i;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-requester (inst/data) arbiter for one SRAM-like memory port with in-order response routing.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin instead of data-over-inst priority.
//
// state     | meaning
// LOCK_IDLE | no grant held; owner chosen by priority policy each cycle
// LOCK_HELD | request visible but not yet accepted; owner frozen to lock_id_q
module mem_req_arbiter import mem_arb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_req_i,
  input  logic          inst_wr_i,
  input  logic [1:0]    inst_size_i,
  input  logic [3:0]    inst_wstrb_i,
  input  logic [AW-1:0] inst_addr_i,
  input  logic [DW-1:0] inst_wdata_i,
  output logic          inst_addr_ok_o,
  output logic          inst_data_ok_o,
  output logic [DW-1:0] inst_rdata_o,
  input  logic          data_req_i,
  input  logic          data_wr_i,
  input  logic [1:0]    data_size_i,
  input  logic [3:0]    data_wstrb_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_addr_ok_o,
  output logic          data_data_ok_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          mem_req_o,
  output logic          mem_wr_o,
  output logic [1:0]    mem_size_o,
  output logic [3:0]    mem_wstrb_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_addr_ok_i,
  input  logic          mem_data_ok_i,
  input  logic [DW-1:0] mem_rdata_i
);

  lock_state_e state_q, state_d;
  logic        lock_id_q, lock_id_d;
  logic        pref_id, sel_id, grant_req;
  logic        accept, pop;
  logic        fifo_full, fifo_empty, head_id;
  logic [$clog2(DEPTH):0] fifo_count;
  arb_req_t    inst_f, data_f, mem_f;

  assign inst_f = '{wr: inst_wr_i, size: inst_size_i, wstrb: inst_wstrb_i,
                    addr: ARB_AW'(inst_addr_i), wdata: ARB_DW'(inst_wdata_i)};
  assign data_f = '{wr: data_wr_i, size: data_size_i, wstrb: data_wstrb_i,
                    addr: ARB_AW'(data_addr_i), wdata: ARB_DW'(data_wdata_i)};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = other_id(sel_id);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= ARB_ID_INST;
    else       rr_q <= rr_d;
  end

  assign pref_id = (inst_req_i && data_req_i) ? rr_q
                 : (data_req_i ? ARB_ID_DATA : ARB_ID_INST);
`else
  assign pref_id = data_req_i ? ARB_ID_DATA : ARB_ID_INST;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOCK_IDLE;
      lock_id_q <= ARB_ID_INST;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      LOCK_IDLE: begin
        if (mem_req_o && !mem_addr_ok_i) begin
          state_d   = LOCK_HELD;
          lock_id_d = sel_id;
        end
      end
      LOCK_HELD: begin
        if (accept) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

  always_comb begin
    sel_id    = (state_q == LOCK_HELD) ? lock_id_q : pref_id;
    grant_req = (sel_id == ARB_ID_DATA) ? data_req_i : inst_req_i;
    mem_f     = (sel_id == ARB_ID_DATA) ? data_f : inst_f;
  end

  // No full bypass: a same-cycle pop does not free a slot for this cycle's request.
  assign mem_req_o   = grant_req & ~fifo_full;
  assign mem_wr_o    = mem_f.wr;
  assign mem_size_o  = mem_f.size;
  assign mem_wstrb_o = mem_f.wstrb;
  assign mem_addr_o  = AW'(mem_f.addr);
  assign mem_wdata_o = DW'(mem_f.wdata);

  assign accept         = mem_req_o & mem_addr_ok_i;
  assign inst_addr_ok_o = accept & (sel_id == ARB_ID_INST);
  assign data_addr_ok_o = accept & (sel_id == ARB_ID_DATA);

  assign pop            = mem_data_ok_i & ~fifo_empty;
  assign inst_data_ok_o = pop & (head_id == ARB_ID_INST);
  assign data_data_ok_o = pop & (head_id == ARB_ID_DATA);
  assign inst_rdata_o   = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  arb_id_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .pop_i   (pop),
    .id_in_i (sel_id),
    .head_o  (head_id),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

endmodule
